scroll_controller: RTL and testbench
====================================

SCROLL_CONTROLLER -- requirements
Module: scroll_controller

Interface
REQ-001 SHALL have parameter HWIDTH, default 12, meaning the horizontal counter and offset width.
REQ-002 SHALL have parameter VWIDTH, default 12, meaning the vertical counter and offset width.
REQ-003 SHALL have parameter HSIZE, default 640, meaning the visible width and the horizontal wrap modulus.
REQ-004 SHALL have parameter VSIZE, default 480, meaning the visible height and the vertical wrap modulus.
REQ-005 SHALL have parameter VEL_WIDTH, default 4, meaning the signed per-frame velocity width.
REQ-006 SHALL have ports: clk  in  1  single clock; rst  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have ports: hdata  in  HWIDTH  current pixel column; vdata  in  VWIDTH  current pixel row.
REQ-008 SHALL have ports: req_valid  in  1  offset update request; req_ready  out  1  controller can accept a request.
REQ-009 SHALL have ports: req_hoffset  in  signed HWIDTH  requested horizontal offset; req_voffset  in  signed VWIDTH  requested vertical offset.
REQ-010 SHALL have ports: hoffset  out  signed HWIDTH  applied horizontal offset; voffset  out  signed VWIDTH  applied vertical offset.
REQ-011 SHALL have ports: frame_tick  out  1  frame-boundary pulse; frame_cnt  out  8  frames since reset.

Function
REQ-012 SHALL define the frame boundary as hdata==0 and vdata==VSIZE; frame_tick SHALL be high for exactly one cycle, in the cycle after the condition's rising edge, and never repeat while the condition is held.
REQ-013 SHALL implement FSM IDLE/PENDING; req_ready SHALL be 1 in IDLE and 0 in PENDING.
REQ-014 SHALL, on req_valid&&req_ready, capture the normalized request into pending registers and go IDLE->PENDING.
REQ-015 SHALL normalize horizontal inputs in range [-(HSIZE-1), HSIZE-1] to [0, HSIZE-1] by adding HSIZE when negative, and handle vertical inputs the same way using VSIZE; behaviour for out-of-range inputs is undefined.
REQ-016 SHALL, in PENDING with frame_tick=1, load hoffset/voffset from the pending registers at that edge (1-cycle latency) and go to IDLE.
REQ-017 SHALL apply a request accepted in the same cycle as frame_tick at the next frame_tick, not the current one.
REQ-018 SHALL hold hoffset/voffset constant between frame_ticks, so offsets never change mid-frame.
REQ-019 SHALL increment frame_cnt on each frame_tick, wrapping from 255 to 0.

Reset
REQ-020 SHALL, while rst=1 at any time, force state=IDLE, hoffset=0, voffset=0, pending=0, frame_tick=0, frame_cnt=0 and req_ready=1; a pending request SHALL be discarded.
REQ-021 SHALL not generate a frame_tick from a boundary condition already true when rst deasserts.

Configuration
REQ-022 SHALL gate the velocity feature with macro SCROLL_VELOCITY_EN.
REQ-023 SHALL, with SCROLL_VELOCITY_EN defined, add inputs vel_h and vel_v (signed VEL_WIDTH each); on every frame_tick in IDLE, each offset SHALL become (offset+vel) mod size within [0, size-1]; in PENDING the request SHALL override velocity for that frame.
REQ-024 SHALL, without SCROLL_VELOCITY_EN, omit the velocity ports and logic entirely, and offsets SHALL change only via requests.

Structure
REQ-025 SHALL place the state enum type (IDLE, PENDING) and the default HSIZE/VSIZE constants in shared package layer_pkg.
REQ-026 SHALL implement modular wrap arithmetic in one sub-module, wrap_add (signed addend, modulus parameter, result in [0, mod-1]), instantiated once per axis.

Verification
REQ-027 SHALL cover: req (100,50) in IDLE, then boundary -> req_ready drops next cycle; hoffset=100, voffset=50 exactly one cycle after frame_tick.
REQ-028 SHALL cover: req (-10,-1) -> applied offsets (630,479).
REQ-029 SHALL cover: request accepted in the frame_tick cycle -> offsets unchanged at that tick and applied at the following tick.
REQ-030 SHALL cover: boundary condition held for 5 cycles -> exactly one frame_tick; 256 frames -> frame_cnt returns to 0.
REQ-031 SHALL cover: rst asserted in PENDING -> offsets 0, req_ready=1, and the pending value never applied.
REQ-032 SHALL cover, with SCROLL_VELOCITY_EN: vel_h=3 from hoffset 638 -> 1 after one frame; vel_v=-2 from 0 -> 478.

Source files
------------

// File: rtl/layer_pkg.sv
// -----------------------------------------------------------------------------
// layer_pkg
// Shared types and constants for the display layer blocks.
//   state_t        : scroll controller request FSM (IDLE / PENDING)
//   HSIZE_DEFAULT  : default visible width  (horizontal wrap modulus)
//   VSIZE_DEFAULT  : default visible height (vertical wrap modulus)
// -----------------------------------------------------------------------------
package layer_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam int HSIZE_DEFAULT = 640;
    localparam int VSIZE_DEFAULT = 480;

endpackage

// File: rtl/wrap_add.sv
// -----------------------------------------------------------------------------
// wrap_add
// Modular addition: result = (base + addend) mod MOD, in [0, MOD-1].
// base is assumed to lie in [0, MOD-1] and |addend| < MOD, so a single
// correction step (add or subtract MOD once) is sufficient.
// Ports:
//   base   in  WIDTH            unsigned starting value
//   addend in  signed ADD_WIDTH signed step
//   result out WIDTH            wrapped sum
// -----------------------------------------------------------------------------
module wrap_add #(
    parameter int WIDTH     = 12,
    parameter int ADD_WIDTH = 12,
    parameter int MOD       = 640
) (
    input  logic [WIDTH-1:0]            base,
    input  logic signed [ADD_WIDTH-1:0] addend,
    output logic [WIDTH-1:0]            result
);

    // Two guard bits: one for sign, one for the carry past MOD.
    localparam int SW = ((ADD_WIDTH > WIDTH) ? ADD_WIDTH : WIDTH) + 2;
    localparam logic signed [SW-1:0] MOD_S = SW'(MOD);

    logic signed [SW-1:0] sum;

    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        sum    = $signed({{(SW-WIDTH){1'b0}}, base}) + SW'(addend);
        result = WIDTH'(sum);
        if (sum < 0) begin
            result = WIDTH'(sum + MOD_S);
        end else if (sum >= MOD_S) begin
            result = WIDTH'(sum - MOD_S);
        end
    end

endmodule

// File: rtl/scroll_controller.sv
// -----------------------------------------------------------------------------
// scroll_controller
// Holds the horizontal/vertical scroll offsets of a display layer and changes
// them only on a frame boundary, so a frame is never drawn with two offsets.
// Requests are normalised into [0, size-1], parked in pending registers and
// applied at the next frame_tick.
//
// Optional feature (macro SCROLL_VELOCITY_EN): adds vel_h / vel_v; on every
// frame_tick with no pending request, each offset advances by its velocity
// modulo the visible size. A pending request overrides velocity that frame.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   hdata, vdata             current pixel column / row
//   req_valid, req_ready     offset update handshake
//   req_hoffset, req_voffset requested offsets (signed)
//   hoffset, voffset         applied offsets (signed, always in [0, size-1])
//   frame_tick               one-cycle pulse after the frame boundary rises
//   frame_cnt                frames since reset, wraps at 256
//   vel_h, vel_v             per-frame velocity (SCROLL_VELOCITY_EN only)
// -----------------------------------------------------------------------------
module scroll_controller
    import layer_pkg::*;
#(
    parameter int HWIDTH    = 12,
    parameter int VWIDTH    = 12,
    parameter int HSIZE     = HSIZE_DEFAULT,
    parameter int VSIZE     = VSIZE_DEFAULT,
    parameter int VEL_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [HWIDTH-1:0]        hdata,
    input  logic [VWIDTH-1:0]        vdata,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic signed [HWIDTH-1:0] req_hoffset,
    input  logic signed [VWIDTH-1:0] req_voffset,
    output logic signed [HWIDTH-1:0] hoffset,
    output logic signed [VWIDTH-1:0] voffset,
    output logic                     frame_tick,
    output logic [7:0]               frame_cnt
`ifdef SCROLL_VELOCITY_EN
    ,
    input  logic signed [VEL_WIDTH-1:0] vel_h,
    input  logic signed [VEL_WIDTH-1:0] vel_v
`endif
);

    state_t state, state_next;

    logic              boundary, boundary_q;
    logic              accept;
    logic [HWIDTH-1:0] norm_h, pend_h, hoff_q;
    logic [VWIDTH-1:0] norm_v, pend_v, voff_q;

    assign boundary = (hdata == '0) && (vdata == VWIDTH'(VSIZE));
    assign accept   = req_valid && req_ready;
    assign hoffset  = $signed(hoff_q);
    assign voffset  = $signed(voff_q);

    // Normalisation of a request is a wrap around zero.
    wrap_add #(.WIDTH(HWIDTH), .ADD_WIDTH(HWIDTH), .MOD(HSIZE)) u_norm_h (
        .base   ('0),
        .addend (req_hoffset),
        .result (norm_h)
    );

    wrap_add #(.WIDTH(VWIDTH), .ADD_WIDTH(VWIDTH), .MOD(VSIZE)) u_norm_v (
        .base   ('0),
        .addend (req_voffset),
        .result (norm_v)
    );

`ifdef SCROLL_VELOCITY_EN
    logic [HWIDTH-1:0] step_h;
    logic [VWIDTH-1:0] step_v;

    wrap_add #(.WIDTH(HWIDTH), .ADD_WIDTH(VEL_WIDTH), .MOD(HSIZE)) u_step_h (
        .base   (hoff_q),
        .addend (vel_h),
        .result (step_h)
    );

    wrap_add #(.WIDTH(VWIDTH), .ADD_WIDTH(VEL_WIDTH), .MOD(VSIZE)) u_step_v (
        .base   (voff_q),
        .addend (vel_v),
        .result (step_v)
    );
`endif

    // Frame boundary edge detect. boundary_q resets high so a boundary that is
    // already present when reset releases does not count as a rising edge.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boundary_q <= 1'b1;
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            boundary_q <= boundary;
            frame_tick <= boundary && !boundary_q;
            if (frame_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request accepted while frame_tick is high lands in PENDING and waits
    // for the next tick; the current tick has already been consumed in IDLE.
    always_comb begin
        state_next = state;
        req_ready  = (state == IDLE);
        case (state)
            IDLE:    if (accept)     state_next = PENDING;
            PENDING: if (frame_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_h <= '0;
            pend_v <= '0;
            hoff_q <= '0;
            voff_q <= '0;
        end else begin
            if (accept) begin
                pend_h <= norm_h;
                pend_v <= norm_v;
            end
            if (state == PENDING && frame_tick) begin
                hoff_q <= pend_h;
                voff_q <= pend_v;
            end
`ifdef SCROLL_VELOCITY_EN
            else if (frame_tick) begin
                hoff_q <= step_h;
                voff_q <= step_v;
            end
`endif
        end
    end

endmodule

// File: tb/tb_scroll_controller.sv
// -----------------------------------------------------------------------------
// tb_scroll_controller
// Scoreboard bench: each driven frame boundary pushes the expected offsets and
// frame count; a monitor pops and compares one cycle after every frame_tick.
// Velocity scenarios are compiled in when SCROLL_VELOCITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_scroll_controller;

    localparam int HS = 640;
    localparam int VS = 480;

    logic               clk = 1'b0;
    logic               rst;
    logic [11:0]        hdata;
    logic [11:0]        vdata;
    logic               req_valid;
    logic               req_ready;
    logic signed [11:0] req_hoffset;
    logic signed [11:0] req_voffset;
    logic signed [11:0] hoffset;
    logic signed [11:0] voffset;
    logic               frame_tick;
    logic [7:0]         frame_cnt;
`ifdef SCROLL_VELOCITY_EN
    logic signed [3:0]  vel_h;
    logic signed [3:0]  vel_v;
`endif

    scroll_controller dut (
        .clk         (clk),
        .rst         (rst),
        .hdata       (hdata),
        .vdata       (vdata),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_hoffset (req_hoffset),
        .req_voffset (req_voffset),
        .hoffset     (hoffset),
        .voffset     (voffset),
        .frame_tick  (frame_tick),
        .frame_cnt   (frame_cnt)
`ifdef SCROLL_VELOCITY_EN
        ,
        .vel_h       (vel_h),
        .vel_v       (vel_v)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_armed = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int tick_count  = 0;

    // Reference model state
    int m_h = 0, m_v = 0, m_ph = 0, m_pv = 0, m_cnt = 0;
    bit m_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int norm(input int x, input int size);
        return (x < 0) ? x + size : x;
    endfunction

    function automatic int wrapm(input int x, input int size);
        return ((x % size) + size) % size;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_ph = 0; m_pv = 0; m_cnt = 0; m_pending = 1'b0;
    endtask

    task automatic model_tick();
        if (m_pending) begin
            m_h = m_ph;
            m_v = m_pv;
            m_pending = 1'b0;
        end
`ifdef SCROLL_VELOCITY_EN
        else begin
            m_h = wrapm(m_h + int'(vel_h), HS);
            m_v = wrapm(m_v + int'(vel_v), VS);
        end
`endif
        m_cnt = (m_cnt + 1) % 256;
        sb.push_back('{h: m_h, v: m_v, cnt: m_cnt});
    endtask

    // Monitor: outputs are compared one cycle after each observed frame_tick.
    always @(negedge clk) begin
        if (mon_armed) begin
            mon_armed = 1'b0;
            if (sb.size() == 0) begin
                check("unexpected_tick", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hoffset", hoffset, mon_e.h);
                check("voffset", voffset, mon_e.v);
                check("frame_cnt", frame_cnt, mon_e.cnt);
            end
        end
        if (!rst && frame_tick) begin
            tick_count++;
            mon_armed = 1'b1;
        end
    end

    // Hold the boundary condition for 'hold' cycles, then leave it.
    task automatic frame(input int hold);
        hdata = 12'd0;
        vdata = 12'(VS);
        model_tick();
        repeat (hold) step();
        hdata = 12'd5;
        vdata = 12'd0;
        repeat (3) step();
    endtask

    task automatic send_req(input int h, input int v);
        check("req_ready_before", req_ready, !m_pending);
        req_valid   = 1'b1;
        req_hoffset = 12'(h);
        req_voffset = 12'(v);
        step();
        req_valid = 1'b0;
        if (!m_pending) begin
            m_pending = 1'b1;
            m_ph = norm(h, HS);
            m_pv = norm(v, VS);
        end
        check("req_ready_drop", req_ready, 0);
    endtask

    // Request presented in the very cycle frame_tick is high.
    task automatic frame_with_req(input int h, input int v);
        hdata = 12'd0;
        vdata = 12'(VS);
        model_tick();
        step();
        check("tick_cycle", frame_tick, 1);
        req_valid   = 1'b1;
        req_hoffset = 12'(h);
        req_voffset = 12'(v);
        step();
        req_valid = 1'b0;
        m_pending = 1'b1;
        m_ph = norm(h, HS);
        m_pv = norm(v, VS);
        hdata = 12'd5;
        vdata = 12'd0;
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int cnt_start;

        rst         = 1'b1;
        hdata       = 12'd5;
        vdata       = 12'd0;
        req_valid   = 1'b0;
        req_hoffset = '0;
        req_voffset = '0;
`ifdef SCROLL_VELOCITY_EN
        vel_h = '0;
        vel_v = '0;
`endif
        repeat (3) step();
        check("rst_hoffset", hoffset, 0);
        check("rst_voffset", voffset, 0);
        check("rst_ready", req_ready, 1);
        check("rst_tick", frame_tick, 0);
        check("rst_cnt", frame_cnt, 0);
        rst = 1'b0;
        step();

        // Basic request then apply
        send_req(100, 50);
        frame(1);
        check("req_ready_back", req_ready, 1);

        // Negative request wraps; offsets hold until the next tick
        send_req(-10, -1);
        repeat (4) step();
        check("hold_h", hoffset, 100);
        check("hold_v", voffset, 50);
        frame(1);

        // Request accepted during the tick cycle waits a full frame
        frame_with_req(20, 30);
        frame(1);

        // Held boundary gives exactly one tick
        t0 = tick_count;
        frame(5);
        check("tick_once", tick_count - t0, 1);

        // Reset while PENDING discards the request
        send_req(200, 100);
        rst = 1'b1;
        model_reset();
        repeat (2) step();
        check("rstp_hoffset", hoffset, 0);
        check("rstp_voffset", voffset, 0);
        check("rstp_ready", req_ready, 1);
        check("rstp_cnt", frame_cnt, 0);
        rst = 1'b0;
        step();
        frame(1);

        // 256 frames bring frame_cnt back to its start value
        cnt_start = m_cnt;
        repeat (256) frame(1);
        check("cnt_wrap", frame_cnt, cnt_start);

        // Boundary already true when reset releases: no tick
        hdata = 12'd0;
        vdata = 12'(VS);
        rst = 1'b1;
        model_reset();
        step();
        check("rsth_tick", frame_tick, 0);
        rst = 1'b0;
        t0 = tick_count;
        repeat (4) step();
        hdata = 12'd5;
        vdata = 12'd0;
        repeat (2) step();
        check("no_tick_after_rst", tick_count - t0, 0);

`ifdef SCROLL_VELOCITY_EN
        send_req(638, 0);
        frame(1);
        vel_h = 4'sd3;
        vel_v = -4'sd2;
        frame(1);
        vel_h = '0;
        vel_v = '0;
        check("vel_h_result", hoffset, 1);
        check("vel_v_result", voffset, 478);
`endif

        repeat (3) step();
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
